// File: rtl/iob_cache_line_buffer_if.sv
// IOb handshake bundle: request (avalid/addr/wdata/wstrb), accept (ready), read response.
// Instantiated once line-wide (front end) and once beat-wide (back end).
interface iob_cache_line_buffer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              avalid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output avalid, addr, wdata, wstrb,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  avalid, addr, wdata, wstrb,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/iob_cache_line_buffer.sv
// Line-to-beat adapter: takes one line request from the data-memory stage and issues it as
// BEATS ascending word-wide IOb requests; read beats are gathered and returned as one line.
module iob_cache_line_buffer #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned WORD_OFFSET_W = 3,
  parameter int unsigned BE_DATA_W     = 32
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  iob_cache_line_buffer_if.slave  buf_iob_io,
  iob_cache_line_buffer_if.master be_iob_io
);
  localparam int unsigned LINE_W     = DATA_W << WORD_OFFSET_W;
  localparam int unsigned BEATS      = LINE_W / BE_DATA_W;
  localparam int unsigned BEAT_W     = $clog2(BEATS);
  localparam int unsigned CNT_W      = BEAT_W + 1;
  localparam int unsigned BE_NBYTES  = BE_DATA_W / 8;
  localparam int unsigned BE_OFF_W   = $clog2(BE_NBYTES);
  localparam int unsigned BUF_ADDR_W = ADDR_W - WORD_OFFSET_W - $clog2(DATA_W / 8);

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e                  state_q, state_d;
  logic [BUF_ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]       wdata_q, wdata_d;
  logic [LINE_W/8-1:0]     wstrb_q, wstrb_d;
  logic [CNT_W-1:0]        req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]        rsp_cnt_q, rsp_cnt_d;
  logic                    avalid_q, avalid_d;
  logic [LINE_W-1:0]       fill_q, fill_d;
  logic [LINE_W-1:0]       rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;

  logic [BEAT_W-1:0] req_idx, rsp_idx;
  logic              be_fire, rsp_fire;

  assign req_idx  = req_cnt_q[BEAT_W-1:0];
  assign rsp_idx  = rsp_cnt_q[BEAT_W-1:0];
  assign be_fire  = avalid_q && be_iob_io.ready;
  // Responses outside a read, or past the last beat, are dropped.
  assign rsp_fire = (state_q == StRd) && be_iob_io.rvalid && (rsp_cnt_q < CNT_W'(BEATS));

  // Next-state: request capture, beat sequencing and response gathering.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    avalid_d  = avalid_q;
    fill_d    = fill_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (buf_iob_io.avalid) begin
          addr_d    = buf_iob_io.addr;
          wdata_d   = buf_iob_io.wdata;
          wstrb_d   = buf_iob_io.wstrb;
          req_cnt_d = '0;
          rsp_cnt_d = '0;
          avalid_d  = 1'b1;
          state_d   = (|buf_iob_io.wstrb) ? StWr : StRd;
        end
      end
      StWr: begin
        if (be_fire) begin
          req_cnt_d = req_cnt_q + CNT_W'(1);
          if (req_cnt_d == CNT_W'(BEATS)) begin
            avalid_d = 1'b0;
            state_d  = StIdle;
          end
        end
      end
      StRd: begin
        // Requests and responses advance independently; several beats may be outstanding.
        if (be_fire) begin
          req_cnt_d = req_cnt_q + CNT_W'(1);
          avalid_d  = (req_cnt_d != CNT_W'(BEATS));
        end
        if (rsp_fire) begin
          fill_d[rsp_idx*BE_DATA_W +: BE_DATA_W] = be_iob_io.rdata;
          rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
          if (rsp_cnt_d == CNT_W'(BEATS)) begin
            // Publish the whole line at once so rdata_o never shows a partial fill.
            rdata_d  = fill_d;
            rvalid_d = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers: synchronous reset, everything frozen while cke_i is low.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        state_q   <= StIdle;
        addr_q    <= '0;
        wdata_q   <= '0;
        wstrb_q   <= '0;
        req_cnt_q <= '0;
        rsp_cnt_q <= '0;
        avalid_q  <= 1'b0;
        fill_q    <= '0;
        rdata_q   <= '0;
        rvalid_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        wstrb_q   <= wstrb_d;
        req_cnt_q <= req_cnt_d;
        rsp_cnt_q <= rsp_cnt_d;
        avalid_q  <= avalid_d;
        fill_q    <= fill_d;
        rdata_q   <= rdata_d;
        rvalid_q  <= rvalid_d;
      end
    end
  end

  // Outputs: beat fields are selected from the captured request by the request counter.
  always_comb begin
    buf_iob_io.ready  = (state_q == StIdle);
    buf_iob_io.rdata  = rdata_q;
    buf_iob_io.rvalid = rvalid_q;
    be_iob_io.avalid  = avalid_q;
    be_iob_io.addr    = {addr_q, req_idx, {BE_OFF_W{1'b0}}};
    be_iob_io.wdata   = wdata_q[req_idx*BE_DATA_W +: BE_DATA_W];
    be_iob_io.wstrb   = '0;
    if (state_q == StWr) begin
      be_iob_io.wstrb = wstrb_q[req_idx*BE_NBYTES +: BE_NBYTES];
    end
  end
endmodule

// File: tb/tb_iob_cache_line_buffer.sv
// Directed bench: back-end memory responder, beat and line scoreboards, latency checks.
module tb_iob_cache_line_buffer;
  logic clk = 1'b0;
  logic cke;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iob_cache_line_buffer_if #(.ADDR_W(27), .DATA_W(256)) buf_if ();
  iob_cache_line_buffer_if #(.ADDR_W(32), .DATA_W(32))  be_if ();

  iob_cache_line_buffer #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .WORD_OFFSET_W(3),
    .BE_DATA_W    (32)
  ) dut (
    .clk_i     (clk),
    .cke_i     (cke),
    .rst_i     (rst),
    .buf_iob_io(buf_if),
    .be_iob_io (be_if)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          chk_wd;
  } beat_t;

  beat_t        exp_beats[$];
  logic [255:0] exp_lines[$];

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int last_pulse = 0;
  int hold_cnt = 0;
  int stall_beat = -1;
  int stall_left = 0;
  bit cur_is_read = 1'b0;
  logic [31:0] mem_base = '0;
  bit          pend_v = 1'b0;
  logic [31:0] pend_d = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Back-end memory: stall control, beat scoreboard, read data one cycle after each accept.
  initial begin
    be_if.ready  = 1'b1;
    be_if.rvalid = 1'b0;
    be_if.rdata  = '0;
    forever begin
      int  idx;
      bit  stall;
      bit  fire;
      beat_t b;
      @(negedge clk);
      #2;
      be_if.rvalid = pend_v;
      be_if.rdata  = pend_d;
      idx = int'(be_if.addr[4:2]);
      if (be_if.avalid && be_if.addr == 32'h208) hold_cnt++;
      stall = be_if.avalid && stall_left > 0 && idx == stall_beat;
      be_if.ready = !stall;
      if (stall) stall_left--;
      fire = be_if.avalid && be_if.ready && cke;
      if (fire) begin
        chk("beat_expected", 256'(exp_beats.size() != 0), 256'(1));
        if (exp_beats.size() != 0) begin
          b = exp_beats.pop_front();
          chk("beat_addr", be_if.addr, b.addr);
          chk("beat_wstrb", be_if.wstrb, b.wstrb);
          if (b.chk_wd) chk("beat_wdata", be_if.wdata, b.wdata);
        end
      end
      pend_v = fire && cur_is_read;
      pend_d = mem_base + 32'(idx);
    end
  end

  // Line-fill monitor: every rvalid_o pulse must match the oldest expected line.
  initial begin
    forever begin
      @(negedge clk);
      if (buf_if.rvalid) begin
        pulses++;
        last_pulse = cyc;
        chk("line_expected", 256'(exp_lines.size() != 0), 256'(1));
        if (exp_lines.size() != 0) chk("line_data", buf_if.rdata, exp_lines.pop_front());
      end
    end
  end

  task automatic push_beats(input logic [26:0] line, input logic [255:0] wd,
                            input logic [31:0] ws, input bit is_wr);
    for (int k = 0; k < 8; k++) begin
      beat_t b;
      b.addr   = {line, 3'(k), 2'b00};
      b.wdata  = wd[k*32 +: 32];
      b.wstrb  = is_wr ? ws[k*4 +: 4] : 4'h0;
      b.chk_wd = is_wr;
      exp_beats.push_back(b);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic send(input logic [26:0] a, input logic [255:0] wd, input logic [31:0] ws,
                      output int t);
    buf_if.avalid = 1'b1;
    buf_if.addr   = a;
    buf_if.wdata  = wd;
    buf_if.wstrb  = ws;
    t = cyc;
    @(negedge clk);
    buf_if.avalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!buf_if.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!buf_if.ready) chk(tag, 256'(buf_if.ready), 256'(1));
  endtask

  task automatic wait_pulse(input string tag, input int p);
    int n = 0;
    while (pulses < p && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (pulses < p) chk(tag, 256'(pulses), 256'(p));
  endtask

  initial begin
    logic [255:0] line_b;
    int t;
    #20000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] wd;
    logic [255:0] line_b;
    int t;
    rst           = 1'b1;
    cke           = 1'b1;
    buf_if.avalid = 1'b0;
    buf_if.addr   = '0;
    buf_if.wdata  = '0;
    buf_if.wstrb  = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 256'(buf_if.ready), 256'(1));
    chk("rst_be_avalid", 256'(be_if.avalid), 256'(0));
    chk("rst_rvalid", 256'(buf_if.rvalid), 256'(0));
    chk("rst_rdata", buf_if.rdata, 256'(0));
    chk("rst_be_addr", 256'(be_if.addr), 256'(0));
    chk("rst_be_wstrb", 256'(be_if.wstrb), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // Full-line write, zero-wait back end.
    cur_is_read = 1'b0;
    wd = mk_line(32'hA0);
    push_beats(27'h10, wd, 32'hFFFF_FFFF, 1'b1);
    send(27'h10, wd, 32'hFFFF_FFFF, t);
    wait_idle("wr_timeout");
    chk("wr_latency", 256'(cyc - t), 256'(9));
    chk("wr_beats_done", 256'(exp_beats.size()), 256'(0));

    // Full-line read, rvalid one cycle after each accept.
    cur_is_read = 1'b1;
    mem_base    = 32'hB0;
    line_b      = mk_line(32'hB0);
    exp_lines.push_back(line_b);
    push_beats(27'h10, '0, '0, 1'b0);
    send(27'h10, '0, '0, t);
    wait_pulse("rd_timeout", 1);
    chk("rd_latency", 256'(last_pulse - t), 256'(10));
    wait_idle("rd_idle_timeout");
    repeat (2) @(negedge clk);
    chk("rd_rdata_hold", buf_if.rdata, line_b);

    // Read with beat 2 stalled three cycles; previous line stays visible meanwhile.
    mem_base   = 32'hC0;
    hold_cnt   = 0;
    stall_beat = 2;
    stall_left = 3;
    exp_lines.push_back(mk_line(32'hC0));
    push_beats(27'h10, '0, '0, 1'b0);
    send(27'h10, '0, '0, t);
    repeat (3) @(negedge clk);
    chk("stall_rdata_stable", buf_if.rdata, line_b);
    wait_pulse("stall_timeout", 2);
    chk("stall_hold_cycles", 256'(hold_cnt), 256'(4));
    wait_idle("stall_idle_timeout");
    stall_beat = -1;

    // Partial write (word 5 only) with a three-cycle clock-enable freeze.
    cur_is_read = 1'b0;
    wd = mk_line(32'h1000);
    push_beats(27'h21, wd, 32'h00F0_0000, 1'b1);
    send(27'h21, wd, 32'h00F0_0000, t);
    @(negedge clk);
    cke = 1'b0;
    repeat (3) @(negedge clk);
    chk("cke_avalid_held", 256'(be_if.avalid), 256'(1));
    cke = 1'b1;
    wait_idle("pw_timeout");
    chk("pw_latency", 256'(cyc - t), 256'(12));
    chk("pw_beats_done", 256'(exp_beats.size()), 256'(0));

    // Reset in the middle of a read: abort, clear line, no pulse.
    cur_is_read = 1'b1;
    mem_base    = 32'hE0;
    push_beats(27'h33, '0, '0, 1'b0);
    send(27'h33, '0, '0, t);
    for (int n = 0; n < 20; n++) begin
      if (be_if.avalid && be_if.addr[4:2] == 3'd4) break;
      @(negedge clk);
    end
    chk("rst_mid_reached", 256'(be_if.addr), 256'(32'h670));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_beats.delete();
    chk("abort_ready", 256'(buf_if.ready), 256'(1));
    chk("abort_avalid", 256'(be_if.avalid), 256'(0));
    chk("abort_rdata", buf_if.rdata, 256'(0));
    chk("abort_rvalid", 256'(buf_if.rvalid), 256'(0));
    repeat (3) @(negedge clk);
    mem_base = 32'hD0;
    exp_lines.push_back(mk_line(32'hD0));
    push_beats(27'h33, '0, '0, 1'b0);
    send(27'h33, '0, '0, t);
    wait_pulse("post_rst_timeout", 3);
    chk("post_rst_latency", 256'(last_pulse - t), 256'(10));
    wait_idle("post_rst_idle_timeout");

    // avalid_i held high: the second copy is only taken once idle again.
    cur_is_read = 1'b0;
    wd = mk_line(32'h5500);
    push_beats(27'h05, wd, 32'hFFFF_FFFF, 1'b1);
    push_beats(27'h05, wd, 32'hFFFF_FFFF, 1'b1);
    buf_if.avalid = 1'b1;
    buf_if.addr   = 27'h05;
    buf_if.wdata  = wd;
    buf_if.wstrb  = 32'hFFFF_FFFF;
    t = cyc;
    @(negedge clk);
    wait_idle("held1_timeout");
    chk("held_first_done", 256'(cyc - t), 256'(9));
    @(negedge clk);
    chk("held_reaccept", 256'(buf_if.ready), 256'(0));
    buf_if.avalid = 1'b0;
    wait_idle("held2_timeout");
    chk("held_second_done", 256'(cyc - t), 256'(18));

    repeat (3) @(negedge clk);
    chk("end_beats_left", 256'(exp_beats.size()), 256'(0));
    chk("end_lines_left", 256'(exp_lines.size()), 256'(0));
    chk("end_pulse_count", 256'(pulses), 256'(3));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
